// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and counter sizing.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int BIT_CNT_W    = 4;
    localparam int PRESCALE_MIN = 4;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Control bundle between the RX line/checkers and the receiver sequencing FSM.
interface uart_rx_ctrl_if #(
    parameter int Prescale_width = 6
);
    logic                                 RX_IN;
    logic                                 PAR_EN;
    logic [Prescale_width-1:0]            Prescale;
    logic                                 strt_glitch;
    logic                                 par_err;
    logic                                 stp_err;
    logic [Prescale_width-1:0]            edge_cnt;
    logic [uart_rx_pkg::BIT_CNT_W-1:0]    bit_cnt;
    logic                                 dat_samp_en;
    logic                                 deser_en;
    logic                                 strt_chk_en;
    logic                                 par_chk_en;
    logic                                 stp_chk_en;
    logic                                 data_valid;
    logic                                 frame_err;

    modport master (
        output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid, frame_err
    );

    modport slave (
        input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid, frame_err
    );

endinterface

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// Oversample (edge) and frame-bit counters with the per-frame prescale latch.
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_en,
    input  logic                  i_latch,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt,
    output logic                  o_bit_end
);

    logic [PRESCALE_W-1:0] r_pre;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [PRESCALE_W-1:0] w_pre_even;
    logic [PRESCALE_W-1:0] w_pre_nxt;

    // Even-ised, floor-clamped prescale captured at frame start
    always_comb begin
        w_pre_even = {i_prescale[PRESCALE_W-1:1], 1'b0};
        if (w_pre_even < PRESCALE_W'(PRESCALE_MIN)) begin
            w_pre_nxt = PRESCALE_W'(PRESCALE_MIN);
        end else begin
            w_pre_nxt = w_pre_even;
        end
    end

    assign o_bit_end  = (r_edge_cnt == (r_pre - PRESCALE_W'(1)));
    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;

    // Counters clear whenever the frame is not running so IDLE always reads zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre      <= PRESCALE_W'(PRESCALE_MIN);
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_latch) begin
            r_pre      <= w_pre_nxt;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (!i_en) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (o_bit_end) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
        end else begin
            r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencing FSM: steps start/data/parity/stop, drives datapath enables
// and the per-frame data_valid / frame_err strobes.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_width     = 8,
    parameter int Prescale_width = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_rx_ctrl_if.slave  rx_if
);

    rx_state_t                 r_state;
    rx_state_t                 w_state_nxt;
    logic                      w_bit_end;
    logic                      w_latch;
    logic                      w_cnt_en;
    logic                      w_last_data;
    logic [Prescale_width-1:0] w_edge_cnt;
    logic [BIT_CNT_W-1:0]      w_bit_cnt;
    logic                      r_err_lat;
    logic                      r_dat_samp_en;
    logic                      r_deser_en;
    logic                      r_strt_chk_en;
    logic                      r_par_chk_en;
    logic                      r_stp_chk_en;
    logic                      r_data_valid;
    logic                      r_frame_err;

    edge_bit_counter #(
        .PRESCALE_W (Prescale_width)
    ) u_edge_bit_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (w_cnt_en),
        .i_latch    (w_latch),
        .i_prescale (rx_if.Prescale),
        .o_edge_cnt (w_edge_cnt),
        .o_bit_cnt  (w_bit_cnt),
        .o_bit_end  (w_bit_end)
    );

    assign w_last_data = (w_bit_cnt == BIT_CNT_W'(DATA_width));

    // Next-state decode; transitions out of a bit happen only at its last oversample
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!rx_if.RX_IN) begin
                    w_state_nxt = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = rx_if.strt_glitch ? IDLE : DATA;
                end else begin
                    w_state_nxt = START;
                end
            end
            DATA: begin
                if (w_bit_end && w_last_data) begin
                    w_state_nxt = rx_if.PAR_EN ? PARITY : STOP;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                end else begin
                    w_state_nxt = PARITY;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Counting stops in the same cycle the FSM heads back to IDLE
    assign w_latch  = (r_state == IDLE) && (w_state_nxt == START);
    assign w_cnt_en = (r_state != IDLE) && (w_state_nxt != IDLE);

    // State register, error latch and registered enables/strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_err_lat     <= 1'b0;
            r_dat_samp_en <= 1'b0;
            r_deser_en    <= 1'b0;
            r_strt_chk_en <= 1'b0;
            r_par_chk_en  <= 1'b0;
            r_stp_chk_en  <= 1'b0;
            r_data_valid  <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_dat_samp_en <= (w_state_nxt != IDLE);
            r_deser_en    <= (w_state_nxt == DATA);
            r_strt_chk_en <= (w_state_nxt == START);
            r_par_chk_en  <= (w_state_nxt == PARITY);
            r_stp_chk_en  <= (w_state_nxt == STOP);
            r_data_valid  <= 1'b0;
            r_frame_err   <= 1'b0;
            if ((r_state == PARITY) && w_bit_end) begin
                r_err_lat <= r_err_lat | rx_if.par_err;
            end
            if ((r_state == STOP) && w_bit_end) begin
                r_err_lat <= 1'b0;
                if (r_err_lat || rx_if.stp_err) begin
                    r_frame_err <= 1'b1;
                end else begin
                    r_data_valid <= 1'b1;
                end
            end
        end
    end

    assign rx_if.edge_cnt    = w_edge_cnt;
    assign rx_if.bit_cnt     = w_bit_cnt;
    assign rx_if.dat_samp_en = r_dat_samp_en;
    assign rx_if.deser_en    = r_deser_en;
    assign rx_if.strt_chk_en = r_strt_chk_en;
    assign rx_if.par_chk_en  = r_par_chk_en;
    assign rx_if.stp_chk_en  = r_stp_chk_en;
    assign rx_if.data_valid  = r_data_valid;
    assign rx_if.frame_err   = r_frame_err;

endmodule
